// File: rtl/mmm_modexp_ctrl.sv
// Sequencer for a bit-serial Montgomery multiplier computing base^exponent mod modulus.
// Latency: (WIDTH+4) cycles per multiply, 3+WIDTH+popcount(E) multiplies, plus one DONE cycle.
// Backpressure: none; start is honoured only in IDLE and ignored otherwise.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start                    one-cycle request, accepted only when idle
//   base/exponent/modulus    operands P, E, M (M odd, P < M); latched on accept
//   const_r2                 R^2 mod M with R = 2^WIDTH, latched on accept
//   busy, done, result       status; done pulses once, result holds until the next final read
//   mm_ena/mm_clear/mm_ld_a  multiplier control strobes
//   mm_ld_r/mm_lock          multiplier result capture / hold
//   mm_a, mm_b, mm_m, mm_r   multiplier operands, modulus and product
//
// Optional build macro MODEXP_SKIP_LEADING_ZEROS_EN: start the bit loop at the most
// significant set bit of E (and skip it entirely for E=0). Results are unchanged.

module mmm_modexp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] const_r2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mm_ena,
  output logic             mm_clear,
  output logic             mm_ld_a,
  output logic             mm_ld_r,
  output logic             mm_lock,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_m,
  input  logic [WIDTH-1:0] mm_r
);

  // Counter width for both the iteration counter and the exponent bit index.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [CW-1:0]    CNT_TOP   = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TO_MONT_P,
    ST_TO_MONT_X,
    ST_SQR,
    ST_MUL,
    ST_FROM_MONT,
    ST_DONE
  } top_state_e;

  typedef enum logic [2:0] {
    MS_CLR,
    MS_LOAD,
    MS_ITER,
    MS_CAPT,
    MS_RD
  } mul_state_e;

  top_state_e       top_q,    top_d;
  mul_state_e       ms_q,     ms_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [CW-1:0]    bit_q,    bit_d;
  logic [WIDTH-1:0] base_q,   base_d;
  logic [WIDTH-1:0] exp_q,    exp_d;
  logic [WIDTH-1:0] mod_q,    mod_d;
  logic [WIDTH-1:0] r2_q,     r2_d;
  logic [WIDTH-1:0] pm_q,     pm_d;
  logic [WIDTH-1:0] x_q,      x_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             in_mult;
  logic [CW-1:0]    bit_init;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  // Index of the highest set bit; 0 when v is zero (the zero case is
  // handled separately by bypassing the bit loop).
  function automatic logic [CW-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  assign bit_init = msb_index(exponent);
`else
  assign bit_init = CNT_TOP;
`endif

  // A multiply is in progress in every top state except IDLE and DONE.
  assign in_mult = (top_q != ST_IDLE) && (top_q != ST_DONE);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q    <= ST_IDLE;
      ms_q     <= MS_CLR;
      cnt_q    <= '0;
      bit_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      r2_q     <= '0;
      pm_q     <= '0;
      x_q      <= '0;
      result_q <= '0;
    end else begin
      top_q    <= top_d;
      ms_q     <= ms_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      r2_q     <= r2_d;
      pm_q     <= pm_d;
      x_q      <= x_d;
      result_q <= result_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: top-level square-and-multiply walk plus the per-multiply
  // micro-sequence. The top state only advances on the RD step, so operands
  // derived from top_q/x_q/pm_q stay constant for the whole multiply.
  // ---------------------------------------------------------------------------
  always_comb begin
    top_d    = top_q;
    ms_d     = ms_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    r2_d     = r2_q;
    pm_d     = pm_q;
    x_d      = x_q;
    result_d = result_q;

    case (top_q)
      ST_IDLE: begin
        if (start) begin
          base_d = base;
          exp_d  = exponent;
          mod_d  = modulus;
          r2_d   = const_r2;
          bit_d  = bit_init;
          ms_d   = MS_CLR;
          top_d  = ST_TO_MONT_P;
        end
      end

      ST_DONE: begin
        // start here is deliberately not looked at; a new request has to
        // arrive once the block is back in IDLE.
        top_d = ST_IDLE;
      end

      default: begin
        case (ms_q)
          MS_CLR:  ms_d = MS_LOAD;
          MS_LOAD: begin
            ms_d  = MS_ITER;
            cnt_d = CNT_TOP;
          end
          MS_ITER: begin
            if (cnt_q == '0) ms_d = MS_CAPT;
            else             cnt_d = cnt_q - 1'b1;
          end
          MS_CAPT: ms_d = MS_RD;
          MS_RD: begin
            ms_d = MS_CLR;
            case (top_q)
              ST_TO_MONT_P: begin
                pm_d  = mm_r;
                top_d = ST_TO_MONT_X;
              end
              ST_TO_MONT_X: begin
                x_d   = mm_r;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                top_d = (exp_q == '0) ? ST_FROM_MONT : ST_SQR;
`else
                top_d = ST_SQR;
`endif
              end
              ST_SQR: begin
                x_d = mm_r;
                if (exp_q[bit_q]) begin
                  top_d = ST_MUL;
                end else if (bit_q == '0) begin
                  top_d = ST_FROM_MONT;
                end else begin
                  bit_d = bit_q - 1'b1;
                  top_d = ST_SQR;
                end
              end
              ST_MUL: begin
                x_d = mm_r;
                if (bit_q == '0) begin
                  top_d = ST_FROM_MONT;
                end else begin
                  bit_d = bit_q - 1'b1;
                  top_d = ST_SQR;
                end
              end
              ST_FROM_MONT: begin
                result_d = mm_r;
                top_d    = ST_DONE;
              end
              default: top_d = ST_IDLE;
            endcase
          end
          default: ms_d = MS_CLR;
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier strobes, decoded from the micro-state. RD carries no strobe:
  // it is the cycle in which the captured product is read back.
  // ---------------------------------------------------------------------------
  always_comb begin
    mm_ena   = 1'b0;
    mm_clear = 1'b0;
    mm_ld_a  = 1'b0;
    mm_ld_r  = 1'b0;
    mm_lock  = 1'b1;
    if (in_mult) begin
      case (ms_q)
        MS_CLR: begin
          mm_clear = 1'b1;
          mm_ena   = 1'b1;
        end
        MS_LOAD: begin
          mm_ld_a = 1'b1;
          mm_ena  = 1'b1;
        end
        MS_ITER: mm_ena = 1'b1;
        MS_CAPT: begin
          mm_ld_r = 1'b1;
          mm_ena  = 1'b1;
          mm_lock = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Operand selection per top state; zero outside a multiply.
  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (top_q)
      ST_TO_MONT_P: begin
        mm_a = base_q;
        mm_b = r2_q;
      end
      ST_TO_MONT_X: begin
        mm_a = ONE;
        mm_b = r2_q;
      end
      ST_SQR: begin
        mm_a = x_q;
        mm_b = x_q;
      end
      ST_MUL: begin
        mm_a = x_q;
        mm_b = pm_q;
      end
      ST_FROM_MONT: begin
        mm_a = x_q;
        mm_b = ONE;
      end
      default: ;
    endcase
  end

  assign mm_m   = mod_q;
  assign busy   = in_mult;
  assign done   = (top_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mmm_modexp_ctrl.sv
module tb_mmm_modexp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base = '0;
  logic [7:0] exponent = '0;
  logic [7:0] modulus = '0;
  logic [7:0] const_r2 = '0;
  logic       busy, done;
  logic [7:0] result;
  logic       mm_ena, mm_clear, mm_ld_a, mm_ld_r, mm_lock;
  logic [7:0] mm_a, mm_b, mm_m;
  logic [7:0] mm_r = '0;

  int errors = 0;
  int checks = 0;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  localparam int LAT_E5  = 97;
  localparam int LAT_E0  = 37;
  localparam int LAT_EFF = 229;
  localparam int LAT_E3  = 85;
`else
  localparam int LAT_E5  = 157;
  localparam int LAT_E0  = 133;
  localparam int LAT_EFF = 229;
  localparam int LAT_E3  = 157;
`endif

  always #5 clk = ~clk;

  mmm_modexp_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base(base), .exponent(exponent), .modulus(modulus), .const_r2(const_r2),
    .busy(busy), .done(done), .result(result),
    .mm_ena(mm_ena), .mm_clear(mm_clear), .mm_ld_a(mm_ld_a), .mm_ld_r(mm_ld_r),
    .mm_lock(mm_lock), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_r(mm_r)
  );

  // Behavioural Montgomery multiplier: a*b*2^-8 mod m, product appears
  // after the capture strobe.
  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] m);
    int t;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) t = t + int'(b);
      if (t[0]) t = t + int'(m);
      t = t >>> 1;
    end
    if (t >= int'(m)) t = t - int'(m);
    return t[7:0];
  endfunction

  always @(posedge clk) begin
    if (mm_ena && mm_ld_r) mm_r <= mont(mm_a, mm_b, mm_m);
  end

  // Presents a request for one cycle; returns #1 into cycle 1 of the run.
  task automatic do_start(input logic [7:0] p, input logic [7:0] e,
                          input logic [7:0] m, input logic [7:0] r2);
    @(posedge clk); #1;
    base = p; exponent = e; modulus = m; const_r2 = r2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done with a cycle budget; cyc is the cycle number done rose in.
  task automatic wait_done(output int cyc, output bit timed_out);
    cyc = 1;
    timed_out = 1'b0;
    while (!done && !timed_out) begin
      if (cyc >= 400) timed_out = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  task automatic check_run(input string name, input int cyc, input bit to,
                           input int lat, input logic [7:0] exp_res);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s_timeout: done never seen within 400 cycles", name);
    end
    checks++;
    if (cyc !== lat) begin
      errors++;
      $display("FAIL %s_latency: got cycle %0d, expected %0d", name, cyc, lat);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL %s_result: got %0d, expected %0d", name, result, exp_res);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_at_done: got %b, expected 0", name, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: got %b one cycle later, expected 0", name, done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, mm_ena, mm_clear, mm_ld_a, mm_ld_r, mm_lock} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 0000001",
               {busy, done, mm_ena, mm_clear, mm_ld_a, mm_ld_r, mm_lock});
    end
    checks++;
    if ({result, mm_a, mm_b, mm_m} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0", {result, mm_a, mm_b, mm_m});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done, mm_ena, mm_clear, mm_ld_a, mm_ld_r, mm_lock} !== 7'b0000001) begin
        errors++;
        $display("FAIL idle_strobes: cycle %0d got %b, expected 0000001", i,
                 {busy, done, mm_ena, mm_clear, mm_ld_a, mm_ld_r, mm_lock});
      end
    end
  endtask

  task automatic test_nominal;
    int cyc;
    bit to;
    do_start(8'd3, 8'd5, 8'd251, 8'd25);
    cyc = 1;
    to = 1'b0;
    while (!done && !to) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL nominal_busy: cycle %0d got %b, expected 1", cyc, busy);
      end
      if (cyc >= 400) to = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check_run("nominal", cyc, to, LAT_E5, 8'd243);
  endtask

  task automatic test_zero_exp;
    int cyc;
    bit to;
    do_start(8'd7, 8'd0, 8'd251, 8'd25);
    wait_done(cyc, to);
    check_run("zero_exp", cyc, to, LAT_E0, 8'd1);
    // P=0 with E>0: result must change from the previous 1 to 0.
    do_start(8'd0, 8'd3, 8'd251, 8'd25);
    wait_done(cyc, to);
    check_run("zero_base", cyc, to, LAT_E3, 8'd0);
  endtask

  task automatic test_all_ones;
    int cyc;
    bit to;
    // 2^255 mod 251 = 2^(255 mod 250) = 32, since 251 is prime.
    do_start(8'd2, 8'hFF, 8'd251, 8'd25);
    wait_done(cyc, to);
    check_run("all_ones", cyc, to, LAT_EFF, 8'd32);
  endtask

  task automatic test_protocol;
    int cyc;
    int pos;
    bit to;
    logic [4:0] exp_strb;
    logic [7:0] a0, b0;
    a0 = '0;
    b0 = '0;
    do_start(8'd3, 8'd5, 8'd251, 8'd25);
    checks++;
    if ({mm_a, mm_b, mm_m} !== {8'd3, 8'd25, 8'd251}) begin
      errors++;
      $display("FAIL proto_first_operands: got %h, expected 0319fb", {mm_a, mm_b, mm_m});
    end
    cyc = 1;
    to = 1'b0;
    while (!done && !to) begin
      pos = (cyc - 1) % 12;
      case (pos)
        0:       exp_strb = 5'b10011;  // {clear, ld_a, ld_r, ena, lock}
        1:       exp_strb = 5'b01011;
        10:      exp_strb = 5'b00110;
        11:      exp_strb = 5'b00001;
        default: exp_strb = 5'b00011;
      endcase
      checks++;
      if ({mm_clear, mm_ld_a, mm_ld_r, mm_ena, mm_lock} !== exp_strb) begin
        errors++;
        $display("FAIL proto_strobes: cycle %0d got %b, expected %b", cyc,
                 {mm_clear, mm_ld_a, mm_ld_r, mm_ena, mm_lock}, exp_strb);
      end
      if (pos == 0) begin
        a0 = mm_a;
        b0 = mm_b;
      end else begin
        checks++;
        if ({mm_a, mm_b} !== {a0, b0}) begin
          errors++;
          $display("FAIL proto_operand_stable: cycle %0d got %h, expected %h", cyc,
                   {mm_a, mm_b}, {a0, b0});
        end
      end
      // A second request mid-run must be ignored.
      if (cyc == 50) begin
        base = 8'd9; exponent = 8'd2; modulus = 8'd13; const_r2 = 8'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (cyc >= 400) to = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    checks++;
    if (cyc !== LAT_E5) begin
      errors++;
      $display("FAIL proto_latency: got cycle %0d, expected %0d", cyc, LAT_E5);
    end
    checks++;
    if (result !== 8'd243) begin
      errors++;
      $display("FAIL proto_result: got %0d, expected 243", result);
    end
    // start coincident with DONE is ignored.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, mm_ena} !== 2'b00) begin
      errors++;
      $display("FAIL proto_start_at_done: got busy,ena=%b, expected 00", {busy, mm_ena});
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit to;
    do_start(8'd3, 8'd5, 8'd251, 8'd25);
    // Cycle 52 lies inside the 5th multiply (cycles 49..60).
    for (int i = 1; i < 52; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, mm_ena, mm_lock} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_abort: got busy,done,ena,lock=%b, expected 0001",
               {busy, done, mm_ena, mm_lock});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_no_done: cycle %0d got busy,done=%b, expected 00",
                 i, {busy, done});
      end
    end
    do_start(8'd2, 8'd3, 8'd251, 8'd25);
    wait_done(cyc, to);
    check_run("after_reset", cyc, to, LAT_E3, 8'd8);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_exp();
    test_all_ones();
    test_protocol();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
